// File: rtl/switch_loader.sv
// switch_loader: captures an X/Y operand pair from the board switches using a
// debounced two-phase handshake switch, and hands each operand to the register
// file as a single-cycle write strobe. A done pulse marks the completed pair.
module switch_loader #(
  parameter int n        = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [n-1:0] sw,
  input  logic         ready_sw,
  output logic         w,
  output logic         Waddr,
  output logic [n-1:0] Wdata,
  output logic         done,
  output logic         phase
);

  typedef enum logic [1:0] {
    WAIT_HI_X = 2'd0,
    WAIT_LO_X = 2'd1,
    WAIT_HI_Y = 2'd2,
    WAIT_LO_Y = 2'd3
  } state_t;

  // Terminal count: a new level is accepted on the cycle the counter sits here.
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  state_t         state;
  logic           s1, s2;
  logic [n-1:0]   d1, d2;
  logic           db;
  logic [7:0]     cnt;

  // Two-flop synchronizers; nothing downstream touches the raw switch inputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d1 <= '0;
      d2 <= '0;
    end else begin
      s1 <= ready_sw;
      s2 <= s1;
      d1 <= sw;
      d2 <= d1;
    end
  end

  // Debouncer: s2 must differ from db for DEBOUNCE consecutive cycles before db follows.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      db  <= 1'b0;
      cnt <= 8'd0;
    end else if (s2 == db) begin
      cnt <= 8'd0;
    end else if (cnt == CNT_LAST) begin
      db  <= s2;
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Handshake FSM; all outputs registered, w and done self-clear every cycle.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= WAIT_HI_X;
      w     <= 1'b0;
      Waddr <= 1'b0;
      Wdata <= '0;
      done  <= 1'b0;
      phase <= 1'b0;
    end else begin
      w    <= 1'b0;
      done <= 1'b0;
      case (state)
        WAIT_HI_X: begin
          if (db) begin
            w     <= 1'b1;
            Waddr <= 1'b0;
            Wdata <= d2;
            state <= WAIT_LO_X;
          end
        end
        WAIT_LO_X: begin
          if (!db) begin
            state <= WAIT_HI_Y;
            phase <= 1'b1;
          end
        end
        WAIT_HI_Y: begin
          if (db) begin
            w     <= 1'b1;
            Waddr <= 1'b1;
            Wdata <= d2;
            state <= WAIT_LO_Y;
          end
        end
        WAIT_LO_Y: begin
          if (!db) begin
            done  <= 1'b1;
            state <= WAIT_HI_X;
            phase <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_HI_X;
          phase <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/switch_loader.md
# switch_loader

Upstream input stage for the picoMIPS register file. It captures two operands from the board switches, using a debounced two-phase handshake switch. Each operand is delivered to the register file as a single-cycle write strobe with address and data. A `done` pulse follows once the second operand has been loaded and the handshake switch released.

## Interface

Parameters:
- `n`, 8, data width; matches register file width
- `DEBOUNCE`, 4, consecutive synchronized cycles a handshake level must hold before it is accepted; legal range 2..255

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `nReset`  in  1  asynchronous, active-low reset
- `sw`  in  n  data switches; asynchronous to `clk`
- `ready_sw`  in  1  handshake switch; asynchronous to `clk`
- `w`  out  1  register-file write strobe, one cycle per operand
- `Waddr`  out  1  destination register: 0 = operand X, 1 = operand Y
- `Wdata`  out  n  write data; holds last written value between strobes
- `done`  out  1  one-cycle pulse after the X/Y pair is complete
- `phase`  out  1  0 = next press loads X, 1 = next press loads Y

## Operation

- **Synchronizers:** two-flop synchronizer on `ready_sw` (s1→s2) and on `sw` (d1→d2). Nothing downstream uses the raw inputs.
- **Debouncer:** register `db` and counter `cnt` (8 bits).
  - If s2 == db: cnt ← 0.
  - If s2 != db and cnt < DEBOUNCE-1: cnt ← cnt+1.
  - If s2 != db and cnt == DEBOUNCE-1: db ← s2 and cnt ← 0.
  - Result: any s2 excursion shorter than DEBOUNCE cycles is discarded.
- **FSM states:**
  - WAIT_HI_X: on db=1, register w←1, Waddr←0, Wdata←d2; go to WAIT_LO_X.
  - WAIT_LO_X: on db=0, go to WAIT_HI_Y.
  - WAIT_HI_Y: on db=1, register w←1, Waddr←1, Wdata←d2; go to WAIT_LO_Y.
  - WAIT_LO_Y: on db=0, register done←1; go to WAIT_HI_X.
- **Output behaviour:**
  - `w` and `done` are registered and deasserted on the next edge; neither is ever high for more than one cycle.
  - `Waddr` and `Wdata` change only on a write and otherwise hold.
  - `phase` is 1 in WAIT_HI_Y and WAIT_LO_Y, and 0 in every other state.
- **Reset:** `nReset` low forces the following regardless of `clk`:
  - state = WAIT_HI_X
  - s1, s2, d1, d2, db, cnt = 0
  - w, Waddr, done, phase = 0
  - Wdata = 0
- **Reset mid-operation:** an operand pair loaded only partially is discarded. The next accepted press loads X.
- **`ready_sw` high through reset release:** this counts as a press once debounced. X is written D+2 edges after release.

## Timing

- Define edge 0 as the first rising edge that samples `ready_sw` high.
- s2 goes high at edge 1; db goes high at edge DEBOUNCE+1.
- `w` is high during the cycle after edge DEBOUNCE+2, i.e. edge 6 for DEBOUNCE=4. This gives a press-to-write latency of DEBOUNCE+2 edges.
- Release follows the same path: `done` is high in the cycle after edge DEBOUNCE+2, counted from the first edge sampling `ready_sw` low in WAIT_LO_Y.
- `Wdata` is the value d2 held at the write edge, i.e. `sw` as sampled two edges earlier. `sw` must therefore be stable from edge DEBOUNCE to the write edge.
- **Bounce:** a toggle inside the debounce window restarts the count. Acceptance occurs DEBOUNCE cycles after the last change of s2.
- **Minimum pair time:** four accepted level changes, each costing ≥ DEBOUNCE+1 cycles after its s2 change.
- **Register-file interface:** the register file must sample `Waddr`/`Wdata` on the same edge on which it sees `w`=1. All three come from the same register stage.

## Test plan

- **Reset values:** `nReset` low for 3 cycles with `sw`=8'hFF and `ready_sw`=0. Required: w=0, done=0, phase=0, Wdata=0, Waddr=0. This holds even when reset is asserted between clock edges.
- **Normal pair, DEBOUNCE=4:**
  - Set `sw`=13 and raise `ready_sw` before edge 0. Required: w=1, Waddr=0, Wdata=13 for exactly one cycle after edge 6.
  - Release `ready_sw`, set `sw`=-120 (8'h88), then press again. Required: w=1, Waddr=1, Wdata=8'h88.
  - Release. Required: done=1 for one cycle, then phase=0.
- **Glitch rejection:** `ready_sw` high for 3 cycles, then low, with DEBOUNCE=4. Required: no `w`, state stays WAIT_HI_X. A 4-cycle high pulse followed by low is accepted: X is written.
- **Bounce:** `ready_sw` toggles 1,0,1,0,1 on successive cycles, then stays high. Required: exactly one `w`, issued DEBOUNCE+1 edges after the last rising s2 change.
- **Reset mid-pair:** after the X write (phase=1), pulse `nReset` low for 1 cycle. Required: phase=0, Wdata=0. The next press writes Waddr=0, and `done` does not appear until a full pair plus release has completed.
- **Hold behaviour:** after the X write of 13, change `sw` to 55 without pressing `ready_sw`. Required: Wdata stays 13 and w stays 0 indefinitely.
